// File: rtl/flappy_game_engine.sv
// flappy_game_engine: frame-rate bird physics, pipe scroll/respawn, collision and scoring.
module flappy_game_engine #(
  parameter int SCREEN_WIDTH = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int PIPE_WIDTH = 57,
  parameter int PIPE_SPACING = 160,
  parameter int GAP_HEIGHT = 120,
  parameter int SCROLL_SPEED = 2,
  parameter int BIRD_LEFT_EDGE = 60,
  parameter int BIRD_WIDTH = 47,
  parameter int BIRD_HEIGHT = 33,
  parameter int BIRD_START_Y = 220,
  parameter int GRAVITY = 1,
  parameter int JUMP_VELOCITY = 8,
  parameter int MAX_FALL = 8,
  parameter int DEAD_HOLD = 60,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int NO_COLLIDE = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        jump,
  output logic [31:0] pipe1x,
  output logic [31:0] pipe2x,
  output logic [31:0] pipe3x,
  output logic [31:0] pipe4x,
  output logic [31:0] pipe1bottomtop,
  output logic [31:0] pipe2bottomtop,
  output logic [31:0] pipe3bottomtop,
  output logic [31:0] pipe4bottomtop,
  output logic [31:0] pipe1yspace,
  output logic [31:0] pipe2yspace,
  output logic [31:0] pipe3yspace,
  output logic [31:0] pipe4yspace,
  output logic [31:0] bird_top_left,
  output logic [31:0] current_score,
  output logic [31:0] high_score
);
  typedef enum logic [1:0] {IDLE, INIT, PLAY, DEAD} state_t;
  localparam logic [11:0] SS = 12'(SCROLL_SPEED);
  localparam logic [11:0] WRAP = 12'(4 * PIPE_SPACING - SCROLL_SPEED);
  localparam logic [11:0] PW = 12'(PIPE_WIDTH);
  localparam logic [11:0] BL = 12'(BIRD_LEFT_EDGE);
  localparam logic [11:0] BR = 12'(BIRD_LEFT_EDGE + BIRD_WIDTH);
  localparam logic signed [11:0] BH = 12'(BIRD_HEIGHT);
  localparam logic signed [11:0] Y_MAX = 12'(SCREEN_HEIGHT - BIRD_HEIGHT);
  localparam logic signed [7:0] MF = 8'(MAX_FALL);
  state_t st;
  logic [15:0] lfsr, score, high, hold, score_nx;
  logic [10:0] px [4];
  logic [9:0] bt [4];
  logic [9:0] ys, y, new_bt;
  logic signed [7:0] vel, v_eff, v_sum, v_nx;
  logic signed [11:0] y_nx;
  logic [11:0] x_nx [4];
  logic [3:0] sc, hit, wrap;
  logic [16:0] score_sum;
  logic [1:0] idx;
  logic jump_prev, jump_pending, rise, jp, chk;
  // an edge arriving with the tick itself still counts for that tick
  assign rise = jump & ~jump_prev;
  assign jp = jump_pending | rise;
  assign new_bt = 10'd160 + 10'(lfsr[7:0]);
  always_comb begin
    v_eff = jp ? 8'(-JUMP_VELOCITY) : vel;
    v_sum = v_eff + 8'(GRAVITY);
    v_nx = v_sum > MF ? MF : v_sum;
    y_nx = $signed({2'b0, y}) + $signed({{4{v_eff[7]}}, v_eff});
    for (int i = 0; i < 4; i++) begin
      wrap[i] = {1'b0, px[i]} <= SS;
      x_nx[i] = wrap[i] ? {1'b0, px[i]} + WRAP : {1'b0, px[i]} - SS;
      sc[i] = ({1'b0, px[i]} + PW > BL) && (x_nx[i] + PW <= BL);
      hit[i] = ({1'b0, px[i]} < BR) && ({1'b0, px[i]} + PW > BL) &&
               (($signed({2'b0, y}) < $signed({2'b0, bt[i]}) - $signed({2'b0, ys})) ||
                ($signed({2'b0, y}) + BH > $signed({2'b0, bt[i]})));
    end
    score_sum = {1'b0, score} + 17'($countones(sc));
    score_nx = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= IDLE;
      lfsr <= LFSR_SEED;
      score <= '0;
      high <= '0;
      hold <= '0;
      ys <= '0;
      y <= '0;
      vel <= '0;
      idx <= '0;
      jump_prev <= 1'b0;
      jump_pending <= 1'b0;
      chk <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        px[i] <= '0;
        bt[i] <= '0;
      end
    end else begin
      lfsr <= lfsr[0] ? (lfsr >> 1) ^ 16'hB400 : lfsr >> 1;
      jump_prev <= jump;
      jump_pending <= (frame_tick && st != INIT) ? 1'b0 : jp;
      chk <= 1'b0;
      case (st)
        IDLE: if (frame_tick && jp) begin
          for (int i = 0; i < 4; i++) px[i] <= 11'(SCREEN_WIDTH + i * PIPE_SPACING);
          bt[0] <= new_bt;
          ys <= 10'(GAP_HEIGHT);
          y <= 10'(BIRD_START_Y);
          vel <= '0;
          score <= '0;
          idx <= 2'd1;
          st <= INIT;
        end
        INIT: begin
          bt[idx] <= new_bt;
          idx <= idx + 2'd1;
          if (idx == 2'd3) st <= PLAY;
        end
        PLAY: if (frame_tick) begin
          for (int i = 0; i < 4; i++) begin
            px[i] <= x_nx[i][10:0];
            if (wrap[i]) bt[i] <= new_bt;
          end
          score <= score_nx;
          chk <= 1'b1;
          if (y_nx >= Y_MAX) begin
            st <= DEAD;
            hold <= '0;
            high <= score_nx > high ? score_nx : high;
          end else if (y_nx[11]) begin
            y <= '0;
            vel <= '0;
          end else begin
            y <= y_nx[9:0];
            vel <= v_nx;
          end
        end else if (chk && |hit && NO_COLLIDE == 0) begin
          st <= DEAD;
          hold <= '0;
          high <= score > high ? score : high;
        end
        DEAD: if (frame_tick) begin
          if (hold < 16'(DEAD_HOLD)) hold <= hold + 16'd1;
          else if (jp) begin
            st <= IDLE;
            score <= '0;
            ys <= '0;
            y <= '0;
            vel <= '0;
            for (int i = 0; i < 4; i++) begin
              px[i] <= '0;
              bt[i] <= '0;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
  assign pipe1x = 32'(px[0]);
  assign pipe2x = 32'(px[1]);
  assign pipe3x = 32'(px[2]);
  assign pipe4x = 32'(px[3]);
  assign pipe1bottomtop = 32'(bt[0]);
  assign pipe2bottomtop = 32'(bt[1]);
  assign pipe3bottomtop = 32'(bt[2]);
  assign pipe4bottomtop = 32'(bt[3]);
  assign pipe1yspace = 32'(ys);
  assign pipe2yspace = 32'(ys);
  assign pipe3yspace = 32'(ys);
  assign pipe4yspace = 32'(ys);
  assign bird_top_left = 32'(y);
  assign current_score = 32'(score);
  assign high_score = 32'(high);
endmodule

// File: tb/tb_flappy_game_engine.sv
// tb_flappy_game_engine: directed checks of start, physics, ceiling, collision, scoring, death hold.
module tb_flappy_game_engine;
  logic clk = 1'b0, reset = 1'b1;
  logic tick_a = 1'b0, jump_a = 1'b0, tick_b = 1'b0, jump_b = 1'b0;
  logic [3:0][31:0] px_a, bt_a, ys_a, px_b, bt_b, ys_b;
  logic [31:0] bird_a, score_a, high_a, bird_b, score_b, high_b, exp_bt;
  logic [15:0] m_lfsr;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  // reference LFSR, free-running from reset exactly like the engine's
  always @(posedge clk or posedge reset)
    if (reset) m_lfsr <= 16'hACE1;
    else m_lfsr <= m_lfsr[0] ? (m_lfsr >> 1) ^ 16'hB400 : m_lfsr >> 1;
  flappy_game_engine u_a (
    .clk(clk), .reset(reset), .frame_tick(tick_a), .jump(jump_a),
    .pipe1x(px_a[0]), .pipe2x(px_a[1]), .pipe3x(px_a[2]), .pipe4x(px_a[3]),
    .pipe1bottomtop(bt_a[0]), .pipe2bottomtop(bt_a[1]), .pipe3bottomtop(bt_a[2]), .pipe4bottomtop(bt_a[3]),
    .pipe1yspace(ys_a[0]), .pipe2yspace(ys_a[1]), .pipe3yspace(ys_a[2]), .pipe4yspace(ys_a[3]),
    .bird_top_left(bird_a), .current_score(score_a), .high_score(high_a)
  );
  flappy_game_engine #(.NO_COLLIDE(1)) u_b (
    .clk(clk), .reset(reset), .frame_tick(tick_b), .jump(jump_b),
    .pipe1x(px_b[0]), .pipe2x(px_b[1]), .pipe3x(px_b[2]), .pipe4x(px_b[3]),
    .pipe1bottomtop(bt_b[0]), .pipe2bottomtop(bt_b[1]), .pipe3bottomtop(bt_b[2]), .pipe4bottomtop(bt_b[3]),
    .pipe1yspace(ys_b[0]), .pipe2yspace(ys_b[1]), .pipe3yspace(ys_b[2]), .pipe4yspace(ys_b[3]),
    .bird_top_left(bird_b), .current_score(score_b), .high_score(high_b)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(input bit b, input bit j);
    @(negedge clk);
    if (b) begin tick_b = 1'b1; jump_b = j; end
    else begin tick_a = 1'b1; jump_a = j; end
    exp_bt = 32'(160 + m_lfsr[7:0]);
    @(negedge clk);
    tick_a = 1'b0; tick_b = 1'b0; jump_a = 1'b0; jump_b = 1'b0;
    repeat (4) @(negedge clk);
  endtask
  task automatic pulse_jump(input bit b);
    @(negedge clk);
    if (b) jump_b = 1'b1; else jump_a = 1'b1;
    @(negedge clk);
    jump_a = 1'b0; jump_b = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("a_reset_zero", 32'(|{px_a, bt_a, ys_a, bird_a, score_a, high_a}), 0);
    check("b_reset_zero", 32'(|{px_b, bt_b, ys_b, bird_b, score_b, high_b}), 0);
    repeat (10) tick(0, 0);
    check("a_idle_zero", 32'(|{px_a, bt_a, ys_a, bird_a, score_a, high_a}), 0);
    pulse_jump(0);
    tick(0, 0);
    for (int i = 0; i < 4; i++) begin
      check("start_px", px_a[i], 32'(640 + 160 * i));
      check("start_ys", ys_a[i], 120);
      check("start_bt_range", 32'(bt_a[i] >= 160 && bt_a[i] <= 415), 1);
    end
    check("start_bird", bird_a, 220);
    check("start_score", score_a, 0);
    repeat (9) tick(0, 0);
    check("fall_t9", bird_a, 256);
    tick(0, 0);
    check("fall_t10_vel8", bird_a, 264);
    repeat (22) tick(0, 0);
    check("fall_t32", bird_a, 440);
    tick(0, 0);
    check("floor_hold", bird_a, 440);
    check("floor_high", high_a, 0);
    repeat (59) tick(0, 0);
    tick(0, 1);
    check("hold60_ignored", bird_a, 440);
    tick(0, 1);
    check("a_dead_to_idle", 32'(|{px_a, bt_a, ys_a, bird_a, score_a, high_a}), 0);
    tick(0, 1);
    check("same_cycle_start", px_a[0], 640);
    tick(0, 1);
    check("jump_t1", bird_a, 212);
    tick(0, 0);
    check("jump_vel_m7", bird_a, 205);
    repeat (25) tick(0, 1);
    check("jump_climb", bird_a, 5);
    tick(0, 1);
    check("ceiling_clamp", bird_a, 0);
    tick(0, 0);
    check("ceiling_vel0", bird_a, 0);
    tick(0, 0);
    check("after_ceiling", bird_a, 1);
    check("px_t30", px_a[0], 580);
    repeat (236) tick(0, 1);
    check("px_t266_no_hit", px_a[0], 108);
    tick(0, 1);
    check("px_t267", px_a[0], 106);
    tick(0, 1);
    check("collide_frozen_px", px_a[0], 106);
    check("collide_frozen_bird", bird_a, 0);
    pulse_jump(1);
    tick(1, 0);
    for (int k = 1; k <= 479; k++) begin
      tick(1, (k % 17) == 1);
      if (k == 318) check("px_t318", px_b[0], 4);
      if (k == 319) begin
        check("px_t319", px_b[0], 2);
        check("score_t319", score_b, 1);
      end
      if (k == 320) begin
        check("respawn_px", px_b[0], 640);
        check("respawn_bt", bt_b[0], exp_bt);
        check("score_t320", score_b, 1);
      end
    end
    check("score_t479", score_b, 3);
    check("bird_t479", bird_b, 199);
    repeat (42) tick(1, 0);
    check("bird_t521", bird_b, 444);
    tick(1, 0);
    check("b_floor_hold", bird_b, 444);
    check("b_dead_score", score_b, 3);
    check("b_high", high_b, 3);
    repeat (29) tick(1, 0);
    tick(1, 1);
    check("b_hold30_ignored", bird_b, 444);
    repeat (29) tick(1, 0);
    tick(1, 1);
    check("b_hold60_ignored", bird_b, 444);
    tick(1, 1);
    check("b_idle_zero", 32'(|{px_b, bt_b, ys_b, bird_b, score_b}), 0);
    check("b_idle_high", high_b, 3);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("b_reset_high", high_b, 0);
    check("a_reset_midgame", 32'(|{px_a, bt_a, ys_a, bird_a, score_a, high_a}), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
